// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte-processing blocks: transform modes,
// ASCII letter bounds and the per-byte transform.
package uart_pkg;

    localparam logic [1:0] MODE_PASS = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_CASE = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    localparam logic [7:0] ASCII_UPPER_LO = 8'h41;
    localparam logic [7:0] ASCII_UPPER_HI = 8'h5A;
    localparam logic [7:0] ASCII_LOWER_LO = 8'h61;
    localparam logic [7:0] ASCII_LOWER_HI = 8'h7A;
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    function automatic logic [7:0] byte_xform(input logic [1:0] mode,
                                              input logic [7:0] d,
                                              input logic [7:0] inc);
        logic [7:0] r;
        r = d;
        case (mode)
            MODE_ADD:  r = d + inc;
            MODE_CASE: begin
                // Upper and lower case letters differ only in bit 5
                if ((d >= ASCII_UPPER_LO && d <= ASCII_UPPER_HI) ||
                    (d >= ASCII_LOWER_LO && d <= ASCII_LOWER_HI))
                    r = d ^ ASCII_CASE_BIT;
            end
            MODE_INV:  r = ~d;
            default:   r = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [DATA_W-1:0]         push_data,
    input  logic                      pop,
    output logic [DATA_W-1:0]         pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo path: transform each received byte by mode, queue it,
// and present it to the transmitter; counts bytes lost while full.
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int          DATA_W       = 8,
    parameter int          DEPTH        = 16,
    parameter int          BACKPRESSURE = 0,
    parameter logic [7:0]  INC_DEFAULT  = 8'd1
) (
    input  logic                      clk_48,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         rx_data,
    input  logic                      rx_data_valid,
    output logic                      rx_data_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_data_valid,
    input  logic                      tx_data_ready,
    input  logic [1:0]                mode,
    input  logic                      inc_load,
    input  logic [DATA_W-1:0]         inc_value,
    output logic [$clog2(DEPTH):0]    level,
    output logic [15:0]               drop_count,
    output logic                      activity
);

    localparam int LW = $clog2(DEPTH) + 1;

    // Handshake: a byte moves on either side only in a cycle where valid && ready
    // are both high; tx_data_valid holds with stable tx_data until tx_data_ready.
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic              ready_q;
    logic [DATA_W-1:0] inc;
    logic [DATA_W-1:0] xformed;
    logic [LW-1:0]     level_next;

    assign tx_data_valid = !empty;
    assign pop           = !empty && tx_data_ready;
    assign rx_data_ready = (BACKPRESSURE != 0) ? ready_q : 1'b1;
    assign push          = rx_data_valid && rx_data_ready && (!full || pop);
    assign drop          = rx_data_valid && rx_data_ready && full && !pop;
    assign xformed       = byte_xform(mode, rx_data, inc);
    assign level_next    = level + LW'(push) - LW'(pop);

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk_48),
        .rst       (rst),
        .push      (push),
        .push_data (xformed),
        .pop       (pop),
        .pop_data  (tx_data),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // ready_q looks one cycle ahead so it never depends on tx_data_ready combinationally
    always_ff @(posedge clk_48) begin
        if (rst) begin
            ready_q    <= 1'b1;
            inc        <= INC_DEFAULT;
            drop_count <= '0;
            activity   <= 1'b0;
        end else begin
            ready_q  <= (level_next != LW'(DEPTH));
            activity <= push;
            if (inc_load) inc <= inc_value;
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: one instance per backpressure setting driven by the
// same stimulus, each compared every cycle against a queue-based reference.
module tb_uart_echo_fifo;

    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_ready;
    logic [1:0] mode;
    logic       inc_load;
    logic [7:0] inc_value;

    logic [1:0] rx_ready;
    logic [1:0] tx_valid;
    logic [1:0] act;
    logic [7:0] tx_data [2];
    logic [4:0] lvl [2];
    logic [15:0] drops [2];

    uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .BACKPRESSURE(0), .INC_DEFAULT(8'd1)) u_bp0 (
        .clk_48(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_valid),
        .rx_data_ready(rx_ready[0]), .tx_data(tx_data[0]), .tx_data_valid(tx_valid[0]),
        .tx_data_ready(tx_ready), .mode(mode), .inc_load(inc_load), .inc_value(inc_value),
        .level(lvl[0]), .drop_count(drops[0]), .activity(act[0])
    );

    uart_echo_fifo #(.DATA_W(8), .DEPTH(DEPTH), .BACKPRESSURE(1), .INC_DEFAULT(8'd1)) u_bp1 (
        .clk_48(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_valid),
        .rx_data_ready(rx_ready[1]), .tx_data(tx_data[1]), .tx_data_valid(tx_valid[1]),
        .tx_data_ready(tx_ready), .mode(mode), .inc_load(inc_load), .inc_value(inc_value),
        .level(lvl[1]), .drop_count(drops[1]), .activity(act[1])
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] ref_xform(input int m, input int d, input int inc);
        int r;
        case (m)
            1:       r = (d + inc) % 256;
            2:       if (d >= 97 && d <= 122) r = d - 32;
                     else if (d >= 65 && d <= 90) r = d + 32;
                     else r = d;
            3:       r = 255 - d;
            default: r = d;
        endcase
        return 8'(r);
    endfunction

    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    logic [15:0] m_drops = '0;
    logic [7:0]  m_inc = 8'd1;
    logic        m_ready1 = 1'b1;
    logic [1:0]  m_act = '0;

    always @(posedge clk) begin
        logic [7:0] b;
        bit pop0, pop1, acc0, acc1;
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
            m_drops  = '0;
            m_inc    = 8'd1;
            m_ready1 = 1'b1;
            m_act    = '0;
        end else begin
            b    = ref_xform(int'(mode), int'(rx_data), int'(m_inc));
            pop0 = (exp_q0.size() > 0) && tx_ready;
            acc0 = rx_valid && ((exp_q0.size() < DEPTH) || pop0);
            if (pop0) void'(exp_q0.pop_front());
            if (acc0) exp_q0.push_back(b);
            if (rx_valid && !acc0 && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
            pop1 = (exp_q1.size() > 0) && tx_ready;
            acc1 = rx_valid && m_ready1;
            if (pop1) void'(exp_q1.pop_front());
            if (acc1) exp_q1.push_back(b);
            m_ready1 = (exp_q1.size() < DEPTH);
            m_act    = {acc1, acc0};
            if (inc_load) m_inc = inc_value;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx_valid0", tx_valid[0], exp_q0.size() != 0);
            if (exp_q0.size() != 0) check("tx_data0", tx_data[0], exp_q0[0]);
            check("level0", lvl[0], exp_q0.size());
            check("drop_count0", drops[0], m_drops);
            check("activity0", act[0], m_act[0]);
            check("rx_ready0", rx_ready[0], 1);
            check("tx_valid1", tx_valid[1], exp_q1.size() != 0);
            if (exp_q1.size() != 0) check("tx_data1", tx_data[1], exp_q1[0]);
            check("level1", lvl[1], exp_q1.size());
            check("drop_count1", drops[1], 0);
            check("activity1", act[1], m_act[1]);
            check("rx_ready1", rx_ready[1], m_ready1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] b);
        check("pop_valid0", tx_valid[0], 1);
        check("pop_data0", tx_data[0], b);
        check("pop_valid1", tx_valid[1], 1);
        check("pop_data1", tx_data[1], b);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && (lvl[0] != 0 || lvl[1] != 0); i++) tick();
        tx_ready = 1'b0;
        check("drain_level0", lvl[0], 0);
        check("drain_level1", lvl[1], 0);
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] bytes [20];
    logic [7:0] x_byte;
    logic [7:0] y_byte;

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        mode = 2'd0; inc_load = 1'b0; inc_value = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_level0", lvl[0], 0);
        check("rst_valid1", tx_valid[1], 0);
        check("rst_ready1", rx_ready[1], 1);
        check("rst_drops0", drops[0], 0);

        // ADD with default increment, held while transmitter stalls
        mode = 2'd1;
        push_byte(8'h41);
        check("t1_data", tx_data[0], 8'h42);
        check("t1_valid", tx_valid[0], 1);
        check("t1_level", lvl[0], 1);
        check("t1_activity", act[0], 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_hold", tx_data[0], 8'h42);
            check("t1_hold_level", lvl[0], 1);
        end
        drain();

        // CASE then INV
        mode = 2'd2;
        push_byte("a");
        push_byte("Z");
        push_byte("5");
        mode = 2'd3;
        push_byte(8'h0F);
        pop_expect(8'h41);
        pop_expect(8'h7A);
        pop_expect(8'h35);
        pop_expect(8'hF0);

        // overflow: drop versus backpressure
        mode = 2'd0;
        for (int i = 0; i < 20; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) push_byte(bytes[i]);
        check("t3_level0", lvl[0], 16);
        check("t3_drops0", drops[0], 4);
        check("t4_level1", lvl[1], 16);
        check("t4_drops1", drops[1], 0);
        check("t4_ready1", rx_ready[1], 0);
        pop_expect(bytes[0]);
        check("t4_ready1_after_pop", rx_ready[1], 1);
        check("t4_level1_after_pop", lvl[1], 15);

        // refill, then push and pop together on a full FIFO
        x_byte = 8'($urandom);
        y_byte = 8'($urandom);
        push_byte(x_byte);
        check("t5_full0", lvl[0], 16);
        check("t5_head0", tx_data[0], bytes[1]);
        rx_data = y_byte; rx_valid = 1'b1; tx_ready = 1'b1;
        tick();
        rx_valid = 1'b0; tx_ready = 1'b0;
        check("t5_level0", lvl[0], 16);
        check("t5_drops0", drops[0], 4);
        check("t5_level1", lvl[1], 15);
        for (int i = 2; i < 16; i++) pop_expect(bytes[i]);
        pop_expect(x_byte);
        check("t5_tail0", tx_data[0], y_byte);
        check("t5_tail_valid0", tx_valid[0], 1);
        check("t5_empty1", tx_valid[1], 0);
        drain();

        // increment load coinciding with an accept
        mode = 2'd1;
        inc_load = 1'b1; inc_value = 8'h10;
        push_byte(8'hFF);
        inc_load = 1'b0;
        push_byte(8'hFF);
        pop_expect(8'h00);
        pop_expect(8'h0F);
        for (int i = 0; i < 5; i++) push_byte(8'($urandom));
        check("t6_level5", lvl[0], 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_level0", lvl[0], 0);
        check("t6_rst_valid0", tx_valid[0], 0);
        check("t6_rst_level1", lvl[1], 0);

        // randomized traffic with varying drain rate
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < 1000; i++) begin
                rx_valid  = ($urandom_range(0, 99) < 60);
                rx_data   = 8'($urandom);
                tx_ready  = ($urandom_range(0, 99) < (phase == 0 ? 30 : (phase == 1 ? 70 : 95)));
                mode      = 2'($urandom_range(0, 3));
                inc_load  = ($urandom_range(0, 19) == 0);
                inc_value = 8'($urandom);
                rst       = ($urandom_range(0, 499) == 0);
                tick();
            end
        end
        rst = 1'b0; rx_valid = 1'b0; inc_load = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
